// File: rtl/bimodal_update_ctrl.sv
// Bimodal predictor update controller: issues table reads for lookups, queues
// {index, predicted direction} per lookup and drives counter updates on resolve.
module bimodal_update_ctrl #(
    parameter int IL    = 10,
    parameter int CL    = 3,
    parameter int DEPTH = 4
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          lk_valid,
    input  logic [IL-1:0] lk_index,
    output logic          lk_ready,
    input  logic          res_valid,
    input  logic          res_taken,
    input  logic [CL-1:0] rdata_c_bits,
    output logic          tbl_rd,
    output logic [IL-1:0] tbl_index,
    output logic          inc_counter,
    output logic          dec_counter,
    output logic          update_enable,
    output logic          correct_prediction,
    output logic          pred_valid,
    output logic          pred_taken,
    output logic [4:0]    inflight_count,
    output logic          full,
    output logic          empty,
    output logic          res_error
);

    localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [5:0] DEPTH_W = 6'(DEPTH);

    logic          s1_valid;
    logic [IL-1:0] s1_index;
    logic [IL-1:0] q_idx  [DEPTH];
    logic          q_pred [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [4:0]    count;
    logic          res_error_q;

    logic          accept;
    logic          do_res;
    logic          push;
    logic          pop;
    logic          q_empty;
    logic          pred_bit;
    logic [5:0]    occupancy;
    logic [IL-1:0] head_idx;
    logic          head_pred;

    // Only the counter MSB carries the prediction; lower bits are the table's business.
    logic unused_rdata_low;
    assign unused_rdata_low = &{1'b0, rdata_c_bits[CL-2:0]};

    assign q_empty   = (count == 5'd0);
    // The stage-1 entry has already claimed a queue slot, so count it as occupied.
    assign occupancy = {1'b0, count} + {5'b0, s1_valid};
    assign lk_ready  = reset & ~res_valid & (occupancy < DEPTH_W);
    assign accept    = lk_valid & lk_ready;
    assign do_res    = reset & res_valid & ~q_empty;
    assign push      = s1_valid;
    assign pop       = do_res;

    assign head_idx  = q_idx[rd_ptr];
    assign head_pred = q_pred[rd_ptr];
    assign pred_bit  = s1_valid & rdata_c_bits[CL-1];

    assign pred_valid     = s1_valid;
    assign pred_taken     = pred_bit;
    assign inflight_count = count;
    assign full           = (count == DEPTH_W[4:0]);
    assign empty          = q_empty;
    assign res_error      = res_error_q;

    always_comb begin
        tbl_rd             = 1'b0;
        tbl_index          = '0;
        update_enable      = 1'b0;
        inc_counter        = 1'b0;
        dec_counter        = 1'b0;
        correct_prediction = 1'b0;
        if (do_res) begin
            update_enable      = 1'b1;
            tbl_index          = head_idx;
            inc_counter        = res_taken;
            dec_counter        = ~res_taken;
            correct_prediction = (head_pred == res_taken);
        end else if (accept) begin
            tbl_rd    = 1'b1;
            tbl_index = lk_index;
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_index    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            res_error_q <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_index <= lk_index;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count       <= count + 5'(push) - 5'(pop);
            res_error_q <= res_valid & q_empty;
        end
    end

    // Payload storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge Clk) begin
        if (push) begin
            q_idx[wr_ptr]  <= s1_index;
            q_pred[wr_ptr] <= pred_bit;
        end
    end

    assert property (@(posedge Clk) disable iff (!reset) push |-> (count != DEPTH_W[4:0]) || pop);
    assert property (@(posedge Clk) disable iff (!reset) !(tbl_rd && update_enable));

endmodule

// File: tb/tb_bimodal_update_ctrl.sv
// Directed bench for bimodal_update_ctrl with hand-computed expectations.
module tb_bimodal_update_ctrl;

    localparam int IL = 10;
    localparam int CL = 3;
    localparam int DEPTH = 4;

    logic          Clk;
    logic          reset;
    logic          lk_valid;
    logic [IL-1:0] lk_index;
    logic          lk_ready;
    logic          res_valid;
    logic          res_taken;
    logic [CL-1:0] rdata_c_bits;
    logic          tbl_rd;
    logic [IL-1:0] tbl_index;
    logic          inc_counter;
    logic          dec_counter;
    logic          update_enable;
    logic          correct_prediction;
    logic          pred_valid;
    logic          pred_taken;
    logic [4:0]    inflight_count;
    logic          full;
    logic          empty;
    logic          res_error;

    int n_checks = 0;
    int n_fails  = 0;

    bimodal_update_ctrl #(.IL(IL), .CL(CL), .DEPTH(DEPTH)) dut (
        .Clk                (Clk),
        .reset              (reset),
        .lk_valid           (lk_valid),
        .lk_index           (lk_index),
        .lk_ready           (lk_ready),
        .res_valid          (res_valid),
        .res_taken          (res_taken),
        .rdata_c_bits       (rdata_c_bits),
        .tbl_rd             (tbl_rd),
        .tbl_index          (tbl_index),
        .inc_counter        (inc_counter),
        .dec_counter        (dec_counter),
        .update_enable      (update_enable),
        .correct_prediction (correct_prediction),
        .pred_valid         (pred_valid),
        .pred_taken         (pred_taken),
        .inflight_count     (inflight_count),
        .full               (full),
        .empty              (empty),
        .res_error          (res_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        lk_valid     = 1'b0;
        lk_index     = '0;
        res_valid    = 1'b0;
        res_taken    = 1'b0;
        rdata_c_bits = '0;
        #2;
        chk_val("rst_empty", 32'(empty), 1);
        chk_val("rst_full", 32'(full), 0);
        chk_val("rst_pred_valid", 32'(pred_valid), 0);
        chk_val("rst_count", 32'(inflight_count), 0);
        chk_val("rst_tbl_rd", 32'(tbl_rd), 0);
        chk_val("rst_upd", 32'(update_enable), 0);
        step();
        step();
        reset = 1'b1;

        // single lookup 0x005, counter 000, then a taken resolve
        step();
        lk_valid = 1'b1; lk_index = 10'h005; rdata_c_bits = 3'b000;
        #1;
        chk_val("t_tbl_rd", 32'(tbl_rd), 1);
        chk_val("t_tbl_index", 32'(tbl_index), 32'h005);
        chk_val("t_pred_valid", 32'(pred_valid), 0);
        step();
        lk_valid = 1'b0;
        #1;
        chk_val("t1_pred_valid", 32'(pred_valid), 1);
        chk_val("t1_pred_taken", 32'(pred_taken), 0);
        chk_val("idle_tbl_rd", 32'(tbl_rd), 0);
        chk_val("idle_tbl_index", 32'(tbl_index), 0);
        step();
        chk_val("t2_count", 32'(inflight_count), 1);
        chk_val("t2_empty", 32'(empty), 0);
        res_valid = 1'b1; res_taken = 1'b1;
        #1;
        chk_val("r_upd", 32'(update_enable), 1);
        chk_val("r_index", 32'(tbl_index), 32'h005);
        chk_val("r_inc", 32'(inc_counter), 1);
        chk_val("r_dec", 32'(dec_counter), 0);
        chk_val("r_correct", 32'(correct_prediction), 0);
        chk_val("r_tbl_rd", 32'(tbl_rd), 0);
        chk_val("r_lk_ready", 32'(lk_ready), 0);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("r1_empty", 32'(empty), 1);
        chk_val("r1_upd", 32'(update_enable), 0);
        chk_val("r1_res_error", 32'(res_error), 0);

        // fill the queue with 0x001..0x004 (all predicted taken)
        step();
        lk_valid = 1'b1; lk_index = 10'h001; rdata_c_bits = 3'b100;
        #1;
        chk_val("f_ready1", 32'(lk_ready), 1);
        step();
        lk_index = 10'h002;
        #1;
        chk_val("f_pred_valid", 32'(pred_valid), 1);
        chk_val("f_pred_taken", 32'(pred_taken), 1);
        step();
        lk_index = 10'h003;
        step();
        lk_index = 10'h004;
        #1;
        chk_val("f_ready4", 32'(lk_ready), 1);
        step();
        lk_index = 10'h00A;
        #1;
        chk_val("f_ready5", 32'(lk_ready), 0);
        chk_val("f_tbl_rd5", 32'(tbl_rd), 0);
        step();
        chk_val("f_full", 32'(full), 1);
        chk_val("f_count", 32'(inflight_count), 4);
        chk_val("f_ready_full", 32'(lk_ready), 0);
        res_valid = 1'b1; res_taken = 1'b1;
        #1;
        chk_val("p1_index", 32'(tbl_index), 32'h001);
        chk_val("p1_correct", 32'(correct_prediction), 1);
        chk_val("p1_tbl_rd", 32'(tbl_rd), 0);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("l5_ready", 32'(lk_ready), 1);
        chk_val("l5_tbl_rd", 32'(tbl_rd), 1);
        chk_val("l5_index", 32'(tbl_index), 32'h00A);
        chk_val("l5_count", 32'(inflight_count), 3);
        step();
        lk_valid = 1'b0; rdata_c_bits = 3'b011;
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk_val("p2_pred_valid", 32'(pred_valid), 1);
        chk_val("p2_pred_taken", 32'(pred_taken), 0);
        chk_val("p2_index", 32'(tbl_index), 32'h002);
        chk_val("p2_dec", 32'(dec_counter), 1);
        chk_val("p2_inc", 32'(inc_counter), 0);
        chk_val("p2_correct", 32'(correct_prediction), 0);
        step();
        res_taken = 1'b1;
        #1;
        chk_val("pp_count", 32'(inflight_count), 3);
        chk_val("p3_index", 32'(tbl_index), 32'h003);
        chk_val("p3_correct", 32'(correct_prediction), 1);
        step();
        #1;
        chk_val("p4_index", 32'(tbl_index), 32'h004);
        step();
        res_taken = 1'b0;
        #1;
        chk_val("p5_index", 32'(tbl_index), 32'h00A);
        chk_val("p5_correct", 32'(correct_prediction), 1);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("drain_empty", 32'(empty), 1);

        // simultaneous lookup and resolve with one entry queued
        lk_valid = 1'b1; lk_index = 10'h010;
        step();
        lk_valid = 1'b0; rdata_c_bits = 3'b011;
        step();
        lk_valid = 1'b1; lk_index = 10'h020;
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk_val("co_ready", 32'(lk_ready), 0);
        chk_val("co_tbl_rd", 32'(tbl_rd), 0);
        chk_val("co_upd", 32'(update_enable), 1);
        chk_val("co_index", 32'(tbl_index), 32'h010);
        chk_val("co_correct", 32'(correct_prediction), 1);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("co1_ready", 32'(lk_ready), 1);
        chk_val("co1_tbl_rd", 32'(tbl_rd), 1);
        chk_val("co1_index", 32'(tbl_index), 32'h020);
        step();
        lk_valid = 1'b0;
        step();
        res_valid = 1'b1;
        #1;
        chk_val("co2_index", 32'(tbl_index), 32'h020);
        step();
        res_valid = 1'b0;

        // resolve on an empty queue
        step();
        res_valid = 1'b1; res_taken = 1'b1;
        #1;
        chk_val("e_upd", 32'(update_enable), 0);
        chk_val("e_inc", 32'(inc_counter), 0);
        chk_val("e_index", 32'(tbl_index), 0);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("e_err_on", 32'(res_error), 1);
        step();
        chk_val("e_err_off", 32'(res_error), 0);

        // resolve while only the stage-1 entry is pending
        lk_valid = 1'b1; lk_index = 10'h030;
        step();
        lk_valid = 1'b0; res_valid = 1'b1;
        #1;
        chk_val("s1_upd", 32'(update_enable), 0);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("s1_err", 32'(res_error), 1);
        chk_val("s1_count", 32'(inflight_count), 1);
        res_valid = 1'b1;
        #1;
        chk_val("s1_index", 32'(tbl_index), 32'h030);
        step();
        res_valid = 1'b0;

        // reset with three entries queued
        lk_valid = 1'b1; lk_index = 10'h101;
        step();
        lk_index = 10'h102;
        step();
        lk_index = 10'h103;
        step();
        lk_valid = 1'b0;
        step();
        chk_val("q3_count", 32'(inflight_count), 3);
        reset = 1'b0;
        #1;
        chk_val("ar_count", 32'(inflight_count), 0);
        chk_val("ar_empty", 32'(empty), 1);
        chk_val("ar_full", 32'(full), 0);
        chk_val("ar_pred_valid", 32'(pred_valid), 0);
        step();
        reset = 1'b1;
        #1;
        chk_val("ar_upd_idle", 32'(update_enable), 0);
        res_valid = 1'b1; res_taken = 1'b1;
        #1;
        chk_val("ar_upd_res", 32'(update_enable), 0);
        step();
        res_valid = 1'b0;
        #1;
        chk_val("ar_res_error", 32'(res_error), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
